// File: rtl/apb_des_stream_if_if.sv
// APB bus bundle for the DES/3DES host interface; master drives the request, slave returns ready/data/error.
interface apb_des_stream_if_if #(
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic              PREADY;
  logic [31:0]       PRDATA;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_des_stream_if.sv
// APB slave front-end for the DES/3DES core: packs words into tagged blocks, unpacks results, holds keys.
// Optional feature macro: APB_SLVERR_EN (drives PSLVERR on dropped pushes, empty reads and wrong-direction accesses).
module apb_des_stream_if #(
  parameter int unsigned IN_DEPTH  = 8,
  parameter int unsigned OUT_DEPTH = 8,
  parameter int unsigned NUM_KEYS  = 3,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  apb_des_stream_if_if.slave      apb,
  output logic [63:0]             blk_data,
  output logic                    blk_dec,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  input  logic [63:0]             res_data,
  input  logic                    res_valid,
  output logic                    res_ready,
  output logic [64*NUM_KEYS-1:0]  key_bus,
  output logic                    key_load
);
  localparam int unsigned IN_AW     = $clog2(IN_DEPTH);
  localparam int unsigned OUT_AW    = $clog2(OUT_DEPTH);
  localparam int unsigned KEY_WORDS = 2 * NUM_KEYS;
  localparam int unsigned KP_W      = $clog2(KEY_WORDS);
  localparam int unsigned KEY_W     = 64 * NUM_KEYS;

  localparam logic [ADDR_W-1:0] A_ENC    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DEC    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_KEY    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_OUT    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_INCNT  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_OUTCNT = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_RSV    = ADDR_W'(7);

  logic [64:0]       r_in_mem  [IN_DEPTH];
  logic [63:0]       r_out_mem [OUT_DEPTH];
  logic [IN_AW:0]    r_in_wptr, r_in_rptr;
  logic [OUT_AW:0]   r_out_wptr, r_out_rptr;
  logic [31:0]       r_in_lo;
  logic              r_in_half, r_out_half;
  logic [KP_W-1:0]   r_key_ptr;
  logic [KEY_W-1:0]  r_key_shadow, r_key_bus;
  logic              r_key_load;

  logic              w_access, w_wr, w_rd;
  logic              w_a_enc, w_a_dec, w_a_key, w_a_wo, w_a_ro;
  logic              w_data_wr, w_in_push, w_in_push_ok, w_in_pop, w_in_empty, w_in_full;
  logic              w_out_rd, w_out_pop, w_out_push, w_out_empty, w_out_full;
  logic              w_key_wr, w_key_last;
  logic [IN_AW:0]    w_in_count;
  logic [OUT_AW:0]   w_out_count;
  logic [63:0]       w_out_head;
  logic [KEY_W-1:0]  w_key_shadow_nxt;
  logic [31:0]       w_prdata;
  logic              w_slverr;

  // Access-phase decode; reset masks the bus so the slave looks idle
  assign w_access = apb.PSEL & apb.PENABLE & ~PRESET;
  assign w_wr     = w_access & apb.PWRITE;
  assign w_rd     = w_access & ~apb.PWRITE;
  assign w_a_enc  = (apb.PADDR == A_ENC);
  assign w_a_dec  = (apb.PADDR == A_DEC);
  assign w_a_key  = (apb.PADDR == A_KEY);
  assign w_a_wo   = w_a_enc | w_a_dec | w_a_key;
  assign w_a_ro   = (apb.PADDR == A_STATUS) | (apb.PADDR == A_OUT) |
                    (apb.PADDR == A_INCNT)  | (apb.PADDR == A_OUTCNT);

  assign w_in_empty   = (r_in_wptr == r_in_rptr);
  assign w_in_full    = (r_in_wptr[IN_AW] != r_in_rptr[IN_AW]) &&
                        (r_in_wptr[IN_AW-1:0] == r_in_rptr[IN_AW-1:0]);
  assign w_in_count   = r_in_wptr - r_in_rptr;
  assign w_data_wr    = w_wr & (w_a_enc | w_a_dec);
  assign w_in_push    = w_data_wr & r_in_half;
  assign w_in_pop     = ~w_in_empty & blk_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign w_in_push_ok = w_in_push & (~w_in_full | w_in_pop);

  assign w_out_empty  = (r_out_wptr == r_out_rptr);
  assign w_out_full   = (r_out_wptr[OUT_AW] != r_out_rptr[OUT_AW]) &&
                        (r_out_wptr[OUT_AW-1:0] == r_out_rptr[OUT_AW-1:0]);
  assign w_out_count  = r_out_wptr - r_out_rptr;
  assign w_out_head   = r_out_mem[r_out_rptr[OUT_AW-1:0]];
  assign w_out_rd     = w_rd & (apb.PADDR == A_OUT);
  assign w_out_pop    = w_out_rd & r_out_half & ~w_out_empty;
  assign w_out_push   = res_valid & ~w_out_full;

  assign w_key_wr     = w_wr & w_a_key;
  assign w_key_last   = (r_key_ptr == KP_W'(KEY_WORDS - 1));

  always_comb begin
    w_key_shadow_nxt = r_key_shadow;
    for (int k = 0; k < KEY_WORDS; k++) begin
      if (r_key_ptr == KP_W'(k)) w_key_shadow_nxt[k*32 +: 32] = apb.PWDATA;
    end
  end

  // Read mux reflects state before the access-phase edge
  always_comb begin
    w_prdata = 32'd0;
    if (w_rd) begin
      case (apb.PADDR)
        A_STATUS: w_prdata = {27'd0, (r_key_ptr != '0), r_out_half, r_in_half, w_out_empty, w_in_full};
        A_OUT:    if (!w_out_empty) w_prdata = r_out_half ? w_out_head[63:32] : w_out_head[31:0];
        A_INCNT:  w_prdata = 32'(w_in_count);
        A_OUTCNT: w_prdata = 32'(w_out_count);
        default:  w_prdata = 32'd0;
      endcase
    end
  end

`ifdef APB_SLVERR_EN
  assign w_slverr = w_access & ((w_in_push & w_in_full & ~w_in_pop) | (w_out_rd & w_out_empty) |
                                (apb.PADDR == A_RSV) | (w_wr & w_a_ro) | (w_rd & w_a_wo));
`else
  assign w_slverr = 1'b0;
`endif

  assign apb.PREADY  = w_access;
  assign apb.PRDATA  = w_prdata;
  assign apb.PSLVERR = w_slverr;

  assign blk_data  = r_in_mem[r_in_rptr[IN_AW-1:0]][63:0];
  assign blk_dec   = r_in_mem[r_in_rptr[IN_AW-1:0]][64];
  assign blk_valid = ~w_in_empty;
  assign res_ready = ~w_out_full;
  assign key_bus   = r_key_bus;
  assign key_load  = r_key_load;

  // FIFO storage: contents are don't-care until pointers advance past them
  always_ff @(posedge PCLK) begin
    if (w_in_push_ok) r_in_mem[r_in_wptr[IN_AW-1:0]] <= {w_a_dec, apb.PWDATA, r_in_lo};
    if (w_out_push)   r_out_mem[r_out_wptr[OUT_AW-1:0]] <= res_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_in_wptr    <= '0;
      r_in_rptr    <= '0;
      r_out_wptr   <= '0;
      r_out_rptr   <= '0;
      r_in_lo      <= 32'd0;
      r_in_half    <= 1'b0;
      r_out_half   <= 1'b0;
      r_key_ptr    <= '0;
      r_key_shadow <= '0;
      r_key_bus    <= '0;
      r_key_load   <= 1'b0;
    end else begin
      r_key_load <= 1'b0;
      if (w_data_wr) begin
        r_in_half <= ~r_in_half;
        if (!r_in_half) r_in_lo <= apb.PWDATA;
      end
      if (w_in_push_ok) r_in_wptr <= r_in_wptr + 1'b1;
      if (w_in_pop)     r_in_rptr <= r_in_rptr + 1'b1;
      if (w_out_push)   r_out_wptr <= r_out_wptr + 1'b1;
      if (w_out_pop)    r_out_rptr <= r_out_rptr + 1'b1;
      if (w_out_rd && !w_out_empty) r_out_half <= ~r_out_half;
      if (w_key_wr) begin
        r_key_shadow <= w_key_shadow_nxt;
        if (w_key_last) begin
          r_key_bus  <= w_key_shadow_nxt;
          r_key_ptr  <= '0;
          r_key_load <= 1'b1;
        end else begin
          r_key_ptr <= r_key_ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_des_stream_if.sv
// Directed bench for apb_des_stream_if (single-key build, 8-deep FIFOs).
module tb_apb_des_stream_if;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned IN_DEPTH  = 8;
  localparam int unsigned OUT_DEPTH = 8;
  localparam int unsigned NUM_KEYS  = 1;
`ifdef APB_SLVERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] blk_data;
  logic        blk_dec, blk_valid;
  logic        blk_ready = 1'b0;
  logic [63:0] res_data = 64'd0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [64*NUM_KEYS-1:0] key_bus;
  logic        key_load;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (key_load) pulses++;

  apb_des_stream_if_if #(.ADDR_W(ADDR_W)) apb ();

  apb_des_stream_if #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .NUM_KEYS(NUM_KEYS), .ADDR_W(ADDR_W)) dut (
    .PCLK(clk), .PRESET(rst), .apb(apb),
    .blk_data(blk_data), .blk_dec(blk_dec), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .key_bus(key_bus), .key_load(key_load)
  );

  task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, output logic err);
    @(posedge clk); #1;
    apb.PADDR = a; apb.PWDATA = d; apb.PWRITE = 1'b1; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #3 err = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic err, output logic rdy);
    @(posedge clk); #1;
    apb.PADDR = a; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #3 begin d = apb.PRDATA; err = apb.PSLVERR; rdy = apb.PREADY; end
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL reset_blk_valid got=%b exp=0", blk_valid); end
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL reset_res_ready got=%b exp=1", res_ready); end
    checks++; if (key_load !== 1'b0 || key_bus !== 64'd0) begin failures++; $display("FAIL reset_key got=%b/%h exp=0/0", key_load, key_bus); end
    apb_read(3'd5, d, e, r);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_in_count got=%h exp=0", d); end
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL reset_pready got=%b exp=1", r); end
    apb_read(3'd6, d, e, r);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_out_count got=%h exp=0", d); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL reset_status got=%h exp=2", d); end
  endtask

  task automatic test_key();
    logic [31:0] d; logic e, r;
    apb_write(3'd2, 32'h616E3137, e);
    repeat (2) @(posedge clk); #1;
    checks++; if (pulses !== 0 || key_bus !== 64'd0) begin failures++; $display("FAIL key_partial pulses=%0d bus=%h exp=0/0", pulses, key_bus); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h12) begin failures++; $display("FAIL key_ptr_status got=%h exp=12", d); end
    apb_write(3'd2, 32'h6E617468, e);
    checks++; if (key_bus !== 64'h6E617468_616E3137) begin failures++; $display("FAIL key_commit got=%h exp=6e617468616e3137", key_bus); end
    checks++; if (key_load !== 1'b1) begin failures++; $display("FAIL key_load_high got=%b exp=1", key_load); end
    repeat (3) @(posedge clk); #1;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL key_pulse_count got=%0d exp=1", pulses); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL key_ptr_cleared got=%h exp=2", d); end
  endtask

  task automatic test_pack();
    logic [31:0] d; logic e, r;
    logic [64:0] exp_blk [5];
    blk_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_blk[i] = {1'b0, 32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      apb_write(3'd0, 32'hA000_0000 + 32'(i), e);
      if (i == 0) begin
        checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL pack_half_no_valid got=%b exp=0", blk_valid); end
      end
      apb_write(3'd0, 32'hB000_0000 + 32'(i), e);
    end
    apb_read(3'd5, d, e, r);
    checks++; if (d !== 32'd4) begin failures++; $display("FAIL pack_in_count got=%h exp=4", d); end
    checks++; if (blk_data !== 64'hB0000000_A0000000 || blk_dec !== 1'b0) begin failures++; $display("FAIL pack_head got=%h/%b exp=b0000000a0000000/0", blk_data, blk_dec); end
    exp_blk[4] = {1'b1, 32'hC0DE0002, 32'hC0DE0001};
    apb_write(3'd1, 32'hC0DE0001, e);
    apb_write(3'd1, 32'hC0DE0002, e);
    apb_read(3'd5, d, e, r);
    checks++; if (d !== 32'd5) begin failures++; $display("FAIL pack_in_count_dec got=%h exp=5", d); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({blk_dec, blk_data} !== exp_blk[i] || blk_valid !== 1'b1) begin
        failures++; $display("FAIL pack_drain_%0d got=%b/%h exp=%h", i, blk_valid, {blk_dec, blk_data}, exp_blk[i]);
      end
      blk_ready = 1'b1;
      @(posedge clk); #1;
    end
    blk_ready = 1'b0;
    checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL pack_drained got=%b exp=0", blk_valid); end
  endtask

  task automatic test_in_full();
    logic [31:0] d; logic e, r;
    for (int i = 0; i < IN_DEPTH; i++) begin
      apb_write(3'd0, 32'h1000 + 32'(i), e);
      apb_write(3'd0, 32'h2000 + 32'(i), e);
    end
    apb_read(3'd5, d, e, r);
    checks++; if (d !== 32'(IN_DEPTH)) begin failures++; $display("FAIL full_in_count got=%h exp=%h", d, IN_DEPTH); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL full_status got=%h exp=3", d); end
    apb_write(3'd0, 32'hDEAD, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL full_lo_err got=%b exp=0", e); end
    apb_write(3'd0, 32'hBEEF, e);
    checks++; if (e !== ERR_EXP) begin failures++; $display("FAIL full_drop_err got=%b exp=%b", e, ERR_EXP); end
    apb_read(3'd5, d, e, r);
    checks++; if (d !== 32'(IN_DEPTH)) begin failures++; $display("FAIL full_drop_count got=%h exp=%h", d, IN_DEPTH); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL full_in_half_clear got=%h exp=3", d); end
    checks++; if (blk_data !== 64'h00002000_00001000) begin failures++; $display("FAIL full_head_intact got=%h exp=0000200000001000", blk_data); end
    blk_ready = 1'b1;
    repeat (IN_DEPTH) @(posedge clk);
    #1 blk_ready = 1'b0;
    apb_read(3'd5, d, e, r);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL full_drained got=%h exp=0", d); end
  endtask

  task automatic test_result();
    logic [31:0] d; logic e, r;
    res_data = 64'h11223344_55667788; res_valid = 1'b1;
    @(posedge clk); #1 res_valid = 1'b0;
    apb_read(3'd6, d, e, r);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL res_out_count got=%h exp=1", d); end
    apb_read(3'd4, d, e, r);
    checks++; if (d !== 32'h55667788) begin failures++; $display("FAIL res_lo got=%h exp=55667788", d); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL res_out_half got=%h exp=8", d); end
    apb_read(3'd4, d, e, r);
    checks++; if (d !== 32'h11223344) begin failures++; $display("FAIL res_hi got=%h exp=11223344", d); end
    apb_read(3'd6, d, e, r);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL res_popped got=%h exp=0", d); end
    apb_read(3'd4, d, e, r);
    checks++; if (d !== 32'd0 || e !== ERR_EXP) begin failures++; $display("FAIL res_empty_read got=%h/%b exp=0/%b", d, e, ERR_EXP); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL res_empty_nochange got=%h exp=2", d); end
    apb_read(3'd7, d, e, r);
    checks++; if (d !== 32'd0 || e !== ERR_EXP) begin failures++; $display("FAIL rsv_read got=%h/%b exp=0/%b", d, e, ERR_EXP); end
    apb_read(3'd0, d, e, r);
    checks++; if (d !== 32'd0 || e !== ERR_EXP) begin failures++; $display("FAIL wo_read got=%h/%b exp=0/%b", d, e, ERR_EXP); end
    apb_write(3'd5, 32'hFFFF_FFFF, e);
    checks++; if (e !== ERR_EXP) begin failures++; $display("FAIL ro_write_err got=%b exp=%b", e, ERR_EXP); end
  endtask

  task automatic test_out_full();
    logic [31:0] d; logic e, r;
    res_valid = 1'b1;
    for (int k = 0; k < OUT_DEPTH; k++) begin
      checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL ofull_ready_%0d got=%b exp=1", k, res_ready); end
      res_data = {32'h0F00_0000 + 32'(k), 32'h0E00_0000 + 32'(k)};
      @(posedge clk); #1;
    end
    checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL ofull_not_ready got=%b exp=0", res_ready); end
    res_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1 res_valid = 1'b0;
    apb_read(3'd6, d, e, r);
    checks++; if (d !== 32'(OUT_DEPTH)) begin failures++; $display("FAIL ofull_count got=%h exp=%h", d, OUT_DEPTH); end
    apb_read(3'd4, d, e, r);
    checks++; if (d !== 32'h0E00_0000) begin failures++; $display("FAIL ofull_lo got=%h exp=0e000000", d); end
    apb_read(3'd4, d, e, r);
    checks++; if (d !== 32'h0F00_0000) begin failures++; $display("FAIL ofull_hi got=%h exp=0f000000", d); end
    apb_read(3'd6, d, e, r);
    checks++; if (d !== 32'(OUT_DEPTH - 1) || res_ready !== 1'b1) begin failures++; $display("FAIL ofull_after_pop got=%h/%b exp=%h/1", d, res_ready, OUT_DEPTH - 1); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e, r;
    apb_write(3'd2, 32'h12345678, e);
    apb_write(3'd0, 32'hCAFE, e);
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h14) begin failures++; $display("FAIL mid_status got=%h exp=14", d); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (res_ready !== 1'b1 || blk_valid !== 1'b0 || key_bus !== 64'd0) begin failures++; $display("FAIL mid_reset_outs got=%b/%b/%h exp=1/0/0", res_ready, blk_valid, key_bus); end
    apb_read(3'd3, d, e, r);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL mid_reset_status got=%h exp=2", d); end
    apb_read(3'd6, d, e, r);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL mid_reset_out_count got=%h exp=0", d); end
    apb_write(3'd2, 32'hAAAA0000, e);
    apb_write(3'd2, 32'hBBBB0000, e);
    checks++; if (key_bus !== 64'hBBBB0000_AAAA0000) begin failures++; $display("FAIL mid_key_restart got=%h exp=bbbb0000aaaa0000", key_bus); end
  endtask

  initial begin
    apb.PADDR = '0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PWDATA = 32'd0;
    test_reset();
    test_key();
    test_pack();
    test_in_full();
    test_result();
    test_out_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
